// File: rtl/exception_ctrl.sv
// exception_ctrl: multi-source exception/IRQ controller for the LEGv8 single-cycle datapath.
// It takes one synchronous exception plus NUM_SRC edge-captured IRQ lines, using fixed priority.
// There is no nesting, and ERET returns through ELR.
// Optional feature macro: EXC_VECTOR_EN gives a separate vector per cause
// (EVBASE + cause*VEC_STRIDE). When it is undefined, every cause vectors to EVBASE.
//
// state   | meaning
// RUN     | normal execution; a pending exception/IRQ is taken this cycle
// HANDLER | inside a handler; IRQs accumulate, Exc raises dfault, ERET returns
module exception_ctrl #(
  parameter int              N          = 64,
  parameter int              NUM_SRC    = 4,
  parameter logic [N-1:0]    EVBASE     = 'hD8,
  parameter logic [N-1:0]    VEC_STRIDE = 'h10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Exc,
  input  logic [3:0]         EStatus,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               ERet,
  input  logic [N-1:0]       NextPC,
  input  logic [N-1:0]       imem_addr,
  input  logic [N-1:0]       ALUBranch,
  input  logic [1:0]         EDataSel,
  output logic               EProc,
  output logic [N-1:0]       EVAddr,
  output logic [N-1:0]       PCBranch,
  output logic [N-1:0]       readData,
  output logic               ExcAck,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic               in_handler,
  output logic               dfault
);

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q, pending_q, pending_d, rise, clr;
  logic [N-1:0]       elr_q, esr_q, err_q;
  logic               exc_ack_q, dfault_q;
  logic [NUM_SRC-1:0] irq_ack_q;
  logic               take, take_irq;
  logic [3:0]         irq_sel;

  assign rise = irq & ~irq_q;

  // Lowest-index pending IRQ; a synchronous exception pre-empts every IRQ.
  always_comb begin
    irq_sel = 4'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (pending_q[k]) irq_sel = 4'(k);
    end
    take     = (state_q == RUN) && (Exc || (|pending_q));
    take_irq = take && !Exc;
    clr      = '0;
    if (take_irq) clr[irq_sel] = 1'b1;
    // A new rise on the line being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: enter on a take, leave on ERET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (take) state_d = HANDLER;
      HANDLER: if (ERet) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Combinational outputs: redirect, vector, return target, MRS read mux.
  always_comb begin
    EProc    = take;
    PCBranch = (state_q == HANDLER && ERet) ? elr_q : ALUBranch;
`ifdef EXC_VECTOR_EN
    if (Exc) EVAddr = EVBASE + N'(EStatus) * VEC_STRIDE;
    else     EVAddr = EVBASE + (N'(irq_sel) + N'(8)) * VEC_STRIDE;
`else
    EVAddr = EVBASE;
`endif
    case (EDataSel)
      2'b00:   readData = elr_q;
      2'b01:   readData = esr_q;
      2'b10:   readData = err_q;
      default: readData = N'(pending_q);
    endcase
  end

  // Saved context, edge capture, acknowledge pulses and the sticky double fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      elr_q     <= '0;
      esr_q     <= '0;
      err_q     <= '0;
      exc_ack_q <= 1'b0;
      irq_ack_q <= '0;
      dfault_q  <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      exc_ack_q <= take;
      irq_ack_q <= clr;
      if (take) begin
        elr_q <= NextPC;
        err_q <= imem_addr;
        if (Exc) esr_q <= N'(EStatus);
        else     esr_q <= {1'b1, {(N-5){1'b0}}, irq_sel};
      end
      if (state_q == HANDLER && Exc) dfault_q <= 1'b1;
    end
  end

  assign ExcAck     = exc_ack_q;
  assign irq_ack    = irq_ack_q;
  assign in_handler = (state_q == HANDLER);
  assign dfault     = dfault_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with hand-computed expectations.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Exc;
  logic [3:0]  EStatus;
  logic [3:0]  irq;
  logic        ERet;
  logic [63:0] NextPC, imem_addr, ALUBranch;
  logic [1:0]  EDataSel;
  logic        EProc, ExcAck, in_handler, dfault;
  logic [63:0] EVAddr, PCBranch, readData;
  logic [3:0]  irq_ack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .reset(reset), .Exc(Exc), .EStatus(EStatus), .irq(irq), .ERet(ERet),
    .NextPC(NextPC), .imem_addr(imem_addr), .ALUBranch(ALUBranch), .EDataSel(EDataSel),
    .EProc(EProc), .EVAddr(EVAddr), .PCBranch(PCBranch), .readData(readData),
    .ExcAck(ExcAck), .irq_ack(irq_ack), .in_handler(in_handler), .dfault(dfault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    EDataSel = sel;
    #1;
    check(tag, readData, exp);
  endtask

  function automatic logic [63:0] vec(input int cause);
`ifdef EXC_VECTOR_EN
    return 64'hD8 + 64'(cause) * 64'h10;
`else
    return 64'hD8 + 64'(cause) * 64'h0;
`endif
  endfunction

  initial begin
    reset = 1'b1; Exc = 0; EStatus = 0; irq = 0; ERet = 0;
    NextPC = 0; imem_addr = 0; ALUBranch = 0; EDataSel = 0;
    tick(); tick();
    check("rst_in_handler", {63'd0, in_handler}, 64'd0);
    check("rst_excack", {63'd0, ExcAck}, 64'd0);
    check("rst_dfault", {63'd0, dfault}, 64'd0);
    rd("rst_elr", 2'b00, 64'd0);
    rd("rst_pending", 2'b11, 64'd0);
    reset = 1'b0;
    tick();

    // Synchronous exception, EStatus=2 at PC 0x40
    Exc = 1; EStatus = 4'd2; imem_addr = 64'h40; NextPC = 64'h44; EDataSel = 2'b00;
    #1;
    check("exc_eproc", {63'd0, EProc}, 64'd1);
    check("exc_evaddr", EVAddr, vec(2));
    check("exc_old_elr", readData, 64'd0);
    tick();
    Exc = 0; EStatus = 0;
    check("exc_ack", {63'd0, ExcAck}, 64'd1);
    check("exc_in_handler", {63'd0, in_handler}, 64'd1);
    check("exc_irq_ack", {60'd0, irq_ack}, 64'd0);
    rd("exc_elr", 2'b00, 64'h44);
    rd("exc_esr", 2'b01, 64'h2);
    rd("exc_err", 2'b10, 64'h40);
    check("hdl_eproc", {63'd0, EProc}, 64'd0);

    // ERET from the handler
    ALUBranch = 64'h1000; ERet = 1;
    #1;
    check("eret_pcbranch", PCBranch, 64'h44);
    tick();
    ERet = 0;
    check("eret_in_handler", {63'd0, in_handler}, 64'd0);
    check("eret_excack_low", {63'd0, ExcAck}, 64'd0);

    // ERET in RUN is ignored
    ERet = 1;
    #1;
    check("run_eret_pcbranch", PCBranch, 64'h1000);
    tick();
    ERet = 0;
    check("run_eret_state", {63'd0, in_handler}, 64'd0);

    // irq[2] and irq[1] rise together; IRQ1 wins
    irq = 4'b0110; NextPC = 64'h84; imem_addr = 64'h80;
    #1;
    check("irq_no_eproc_yet", {63'd0, EProc}, 64'd0);
    tick();
    check("irq_eproc", {63'd0, EProc}, 64'd1);
    check("irq1_evaddr", EVAddr, vec(9));
    rd("irq_pending", 2'b11, 64'h6);
    tick();
    check("irq1_ack", {63'd0, ExcAck}, 64'd1);
    check("irq1_irq_ack", {60'd0, irq_ack}, 64'b0010);
    rd("irq1_esr", 2'b01, 64'h8000_0000_0000_0001);
    rd("irq1_pending", 2'b11, 64'h4);
    ERet = 1;
    #1;
    check("irq1_eret_pcb", PCBranch, 64'h84);
    check("irq1_no_nest", {63'd0, EProc}, 64'd0);
    tick();
    ERet = 0;
    check("irq2_eproc", {63'd0, EProc}, 64'd1);
    check("irq2_evaddr", EVAddr, vec(10));
    tick();
    check("irq2_irq_ack", {60'd0, irq_ack}, 64'b0100);
    rd("irq2_esr", 2'b01, 64'h8000_0000_0000_0002);
    ERet = 1; tick(); ERet = 0;

    // Exc and irq[0] pending together: Exc first
    irq = 4'b0001;
    tick();
    Exc = 1; EStatus = 4'd5; NextPC = 64'h104; imem_addr = 64'h100;
    #1;
    check("exc_prio_evaddr", EVAddr, vec(5));
    tick();
    check("exc_prio_irq_ack", {60'd0, irq_ack}, 64'd0);
    rd("exc_prio_esr", 2'b01, 64'h5);
    rd("exc_prio_pending", 2'b11, 64'h1);
    // Exc in HANDLER raises a double fault
    EStatus = 4'd7; NextPC = 64'h204;
    tick();
    Exc = 0;
    check("dfault_set", {63'd0, dfault}, 64'd1);
    rd("dfault_elr", 2'b00, 64'h104);
    rd("dfault_esr", 2'b01, 64'h5);
    ERet = 1; tick(); ERet = 0;
    check("irq0_eproc", {63'd0, EProc}, 64'd1);
    tick();
    check("irq0_irq_ack", {60'd0, irq_ack}, 64'b0001);
    rd("irq0_esr", 2'b01, 64'h8000_0000_0000_0000);
    check("dfault_sticky", {63'd0, dfault}, 64'd1);
    ERet = 1; tick(); ERet = 0;

    // Exc and ERet in the same RUN cycle: the exception wins
    Exc = 1; ERet = 1; EStatus = 4'd3; ALUBranch = 64'h2000;
    #1;
    check("exc_eret_pcb", PCBranch, 64'h2000);
    tick();
    Exc = 0; ERet = 0;
    check("exc_eret_state", {63'd0, in_handler}, 64'd1);
    rd("exc_eret_esr", 2'b01, 64'h3);

    // Reset mid-handler with a pending IRQ
    irq = 4'b0010;
    tick();
    irq = 4'b0000; reset = 1;
    tick();
    reset = 0;
    #1;
    check("rst2_in_handler", {63'd0, in_handler}, 64'd0);
    check("rst2_dfault", {63'd0, dfault}, 64'd0);
    rd("rst2_pending", 2'b11, 64'd0);
    rd("rst2_elr", 2'b00, 64'd0);
    rd("rst2_esr", 2'b01, 64'd0);
    rd("rst2_err", 2'b10, 64'd0);
    check("rst2_eproc", {63'd0, EProc}, 64'd0);

    // IRQ3 vector
    tick();
    irq = 4'b1000;
    tick();
    check("irq3_eproc", {63'd0, EProc}, 64'd1);
    check("irq3_evaddr", EVAddr, vec(11));
    tick();
    check("irq3_irq_ack", {60'd0, irq_ack}, 64'b1000);
    rd("irq3_esr", 2'b01, 64'h8000_0000_0000_0003);
    tick();
    check("ack_pulse_len", {63'd0, ExcAck}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
